// File: rtl/mem_access_stage.sv
// MEM pipeline stage: valid/ready data-memory port, load extract/extend, stall generation, MEM/WB register.
// Optional build macro MEM_MISALIGN_CHECK_EN drops misaligned accesses and pulses misalign.
module mem_access_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pipe_en,
  input  logic [N-1:0] ALUres,
  input  logic [N-1:0] wrData,
  input  logic [N-1:0] NPC4_IN,
  input  logic [6:0]   cwMEM,
  input  logic [4:0]   Rdest_in,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [N-1:0] dmem_addr,
  output logic [N-1:0] dmem_wdata,
  output logic [3:0]   dmem_be,
  input  logic         dmem_ready,
  input  logic         dmem_rvalid,
  input  logic [N-1:0] dmem_rdata,
  output logic         mem_stall,
  output logic         misalign,
  output logic [N-1:0] wb_data,
  output logic [4:0]   wb_rd,
  output logic         wb_we
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] wb_data_q, wb_data_d, hold_q, hold_d;
  logic [4:0]   wb_rd_q, wb_rd_d;
  logic         wb_we_q, wb_we_d;

  logic         mem_rd, mem_wr, ld_unsigned, reg_wr, wb_link;
  logic [1:0]   size, a_lo;
  logic         access, is_store, mis, access_go, complete, req_raw;
  logic [7:0]   ld_b;
  logic [15:0]  ld_h;
  logic [N-1:0] load_ext, wb_next;

  assign mem_rd      = cwMEM[6];
  assign mem_wr      = cwMEM[5];
  assign size        = cwMEM[4:3];
  assign ld_unsigned = cwMEM[2];
  assign reg_wr      = cwMEM[1];
  assign wb_link     = cwMEM[0];
  assign a_lo        = ALUres[1:0];
  assign access      = mem_rd | mem_wr;
  assign is_store    = mem_wr & ~mem_rd;

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign mis       = access & ((size == 2'b01 & a_lo[0]) | (size[1] & (a_lo != 2'b00)));
  assign misalign  = misalign_q;
  assign misalign_d = pipe_en & mis;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
`else
  assign mis      = 1'b0;
  assign misalign = 1'b0;
`endif

  assign access_go = access & ~mis;

  // Store lane steering; size 11 is treated as a word.
  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = wrData;
    case (size)
      2'b00: begin
        dmem_be    = 4'b0001 << a_lo;
        dmem_wdata = {4{wrData[7:0]}};
      end
      2'b01: begin
        dmem_be    = 4'b0011 << {a_lo[1], 1'b0};
        dmem_wdata = {2{wrData[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_b = dmem_rdata[{a_lo, 3'b000} +: 8];
  assign ld_h = dmem_rdata[{a_lo[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = dmem_rdata;
    case (size)
      2'b00:   load_ext = {{(N-8){~ld_unsigned & ld_b[7]}}, ld_b};
      2'b01:   load_ext = {{(N-16){~ld_unsigned & ld_h[15]}}, ld_h};
      default: ;
    endcase
  end

  assign wb_next = wb_link ? NPC4_IN : (mem_rd ? load_ext : ALUres);

  always_comb begin
    state_d  = state_q;
    req_raw  = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE, REQ: begin
        if (access_go) begin
          req_raw = 1'b1;
          if (!dmem_ready)     state_d = REQ;
          else if (!is_store)  state_d = WAIT;
          else begin
            complete = 1'b1;
            state_d  = pipe_en ? IDLE : DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          complete = 1'b1;
          state_d  = pipe_en ? IDLE : DONE;
        end
      end
      DONE: if (pipe_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Combinational port/stall outputs are forced low while reset is asserted.
  assign dmem_req  = req_raw & ~rst;
  assign dmem_we   = dmem_req & is_store;
  assign dmem_addr = {ALUres[N-1:2], 2'b00};
  assign mem_stall = access_go & ~complete & (state_q != DONE) & ~rst;

  always_comb begin
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    wb_we_d   = wb_we_q;
    hold_d    = hold_q;
    if (complete && !pipe_en) hold_d = wb_next;
    if (pipe_en) begin
      if (mem_stall || mis) begin
        wb_we_d = 1'b0;
      end else begin
        wb_we_d   = reg_wr;
        wb_rd_d   = Rdest_in;
        wb_data_d = (state_q == DONE) ? hold_q : wb_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_we_q   <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_we_q   <= wb_we_d;
      hold_q    <= hold_d;
    end
  end

  assign wb_data = wb_data_q;
  assign wb_rd   = wb_rd_q;
  assign wb_we   = wb_we_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the pipeline. Consumes the EX/MEM register outputs: ALU result/address, store data, link address, 7-bit MEM control word and destination register.
- Drives a valid/ready data-memory port and extracts and extends load data.
- Generates a stall while an access is outstanding.
- Holds the MEM/WB pipeline register, whose contents also serve as the WB-stage forwarding source back to execute.

Parameters:
N, 32, datapath/address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
pipe_en  in  1  MEM/WB register enable from hazard unit (0 = freeze)
ALUres  in  N  address / ALU result from EX/MEM
wrData  in  N  store data from EX/MEM
NPC4_IN  in  N  PC+4 link value from EX/MEM
cwMEM  in  7  [6] mem_rd, [5] mem_wr, [4:3] size (00 B, 01 H, 10 W), [2] load_unsigned, [1] reg_wr, [0] wb_link
Rdest_in  in  5  destination register
dmem_req  out  1  request valid
dmem_we  out  1  1 = store
dmem_addr  out  N  word-aligned address ({ALUres[N-1:2],2'b00})
dmem_wdata  out  N  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ready  in  1  request accepted this cycle
dmem_rvalid  in  1  load data valid
dmem_rdata  in  N  load data
mem_stall  out  1  access pending; upstream stages must hold
misalign  out  1  one-cycle flag, misaligned access dropped
wb_data  out  N  MEM/WB write-back / forwarding value
wb_rd  out  5  MEM/WB destination
wb_we  out  1  MEM/WB register-write enable

Behaviour:
- Reset (async): state IDLE, dmem_req=0, mem_stall=0, misalign=0, wb_data=0, wb_rd=0, wb_we=0, hold register=0. Any dmem_rvalid arriving after reset is ignored.
- access = mem_rd | mem_wr. If both bits are set, treat the access as a load.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, access: dmem_req=1 combinationally.
  - ready=1 and store: complete.
  - ready=1 and load: go to WAIT.
  - ready=0: go to REQ.
- REQ: dmem_req held with address, data, we and be stable until ready. Then complete (store) or go to WAIT (load).
- WAIT: on rvalid, the load completes. rvalid is never accepted in the same cycle as the request, so a load spends at least 2 cycles in MEM.
- Completion:
  - pipe_en=1: capture the result into MEM/WB, return to IDLE.
  - pipe_en=0: store the result in the hold register, go to DONE.
- DONE: dmem_req=0, mem_stall=0. When pipe_en=1, capture the held result and go to IDLE. No re-issue of the access.
- mem_stall = access & ~completing_this_cycle & state!=DONE. A store with ready in the IDLE cycle produces no stall.
- MEM/WB register, clocked when pipe_en=1:
  - If mem_stall: bubble (wb_we<=0; wb_data and wb_rd hold).
  - Else: wb_we<=reg_wr, wb_rd<=Rdest_in.
  - wb_data <= NPC4_IN if wb_link; else extended load data if mem_rd; else ALUres.
- pipe_en=0: MEM/WB holds.
- Store lanes:
  - B: be=0001<<a[1:0], wdata=byte replicated x4.
  - H: be=0011<<(2*a[1]), wdata=half replicated x2.
  - W: be=1111.
- Load extract:
  - B: rdata>>(8*a[1:0]).
  - H: rdata>>(16*a[1]).
  - Sign-extend unless load_unsigned. A word load passes through.
- Misaligned: H with a[0]=1, or W with a[1:0]!=0. Handled per the Optional Feature.
- Non-memory instructions pass through in 0 extra cycles.

Optional Feature:
MEM_MISALIGN_CHECK_EN
- Defined: a misaligned access issues no request and produces no stall. misalign=1 for one cycle. The access is written to MEM/WB as a bubble (wb_we=0).
- Undefined: misalign is tied to 0. Low address bits are ignored: H uses a[1], W uses the aligned word. The access proceeds normally.

Test Plan:
1. Pass-through: cwMEM=0000010, ALUres=0x00001234, Rdest=5, pipe_en=1 -> next edge wb_data=0x1234, wb_rd=5, wb_we=1, dmem_req never high, mem_stall=0.
2. SW at 0x100, wrData=0xDEADBEEF, ready=1 in first cycle -> req for 1 cycle, we=1, be=1111, addr=0x100, mem_stall=0, wb_we=reg_wr=0.
3. SH at 0x102, wrData=0x0000ABCD, ready after 3 cycles -> req, addr and be stable for 3 cycles, be=1100, wdata=0xABCDABCD, mem_stall=1 for 3 cycles then 0.
4. LB at 0x103, rdata=0x80000000 with rvalid 2 cycles after accept:
   - signed -> wb_data=0xFFFFFF80.
   - unsigned -> wb_data=0x00000080.
   - In both cases, wb_we=0 while stalled.
5. Load completes with pipe_en=0 -> state DONE, no second request. On a later pipe_en=1, wb_data gets the held value.
6. With MEM_MISALIGN_CHECK_EN, LW at 0x101 -> no req, misalign pulse, wb_we=0. Separately, assert rst during WAIT -> req=0, all outputs 0, a late rvalid is ignored.
